// File: rtl/bc_stage_id_hs.sv
// RV32 instruction-decode stage with a 2-entry elastic buffer (output reg + skid reg).
// Optional opcode legality checking is enabled by defining BC_ID_ILLEGAL_CHECK_EN.

package CG_rvarch_instr_field_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic logic [31:0] get_imm(input logic [31:0] instr);
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:
                get_imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                get_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                get_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                get_imm = {instr[31:12], 12'd0};
            OPC_JAL:
                get_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                get_imm = 32'd0;
        endcase
    endfunction

    function automatic logic is_rd_opcode(input logic [31:0] instr);
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD,
            OPC_OP_IMM, OPC_OP, OPC_SYSTEM: is_rd_opcode = 1'b1;
            default:                        is_rd_opcode = 1'b0;
        endcase
    endfunction

    function automatic logic is_imm_op(input logic [31:0] instr);
        return instr[6:0] == OPC_OP_IMM;
    endfunction

    function automatic logic is_jump_op(input logic [31:0] instr);
        return (instr[6:0] == OPC_JAL) || (instr[6:0] == OPC_JALR);
    endfunction

    function automatic logic is_branch_op(input logic [31:0] instr);
        return instr[6:0] == OPC_BRANCH;
    endfunction

    function automatic logic is_load_op(input logic [31:0] instr);
        return instr[6:0] == OPC_LOAD;
    endfunction

    function automatic logic is_store_op(input logic [31:0] instr);
        return instr[6:0] == OPC_STORE;
    endfunction

    function automatic logic is_legal_opcode(input logic [31:0] instr);
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: is_legal_opcode = 1'b1;
            default:                                              is_legal_opcode = 1'b0;
        endcase
    endfunction

endpackage

module bc_stage_id_hs
    import CG_rvarch_instr_field_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_flush,
    input  logic                   i_instr_valid,
    output logic                   o_instr_ready,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic [PC_WIDTH-1:0]    i_pc,
    output logic                   o_decode_valid,
    input  logic                   i_decode_ready,
    output logic [PC_WIDTH-1:0]    o_pc,
    output logic [2:0]             o_funct3,
    output logic [6:0]             o_funct7,
    output logic [4:0]             o_rs1_addr,
    output logic [4:0]             o_rs2_addr,
    output logic [4:0]             o_rd_addr,
    output logic                   o_rd_wen,
    output logic [DATA_WIDTH-1:0]  o_imm,
    output logic                   o_is_imm_op,
    output logic                   o_is_jump_op,
    output logic                   o_is_branch_op,
    output logic                   o_is_load_op,
    output logic                   o_is_store_op,
    output logic                   o_illegal
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic                  rd_wen;
        logic [DATA_WIDTH-1:0] imm;
        logic                  is_imm;
        logic                  is_jump;
        logic                  is_branch;
        logic                  is_load;
        logic                  is_store;
`ifdef BC_ID_ILLEGAL_CHECK_EN
        logic                  illegal;
`endif
    } bundle_t;

    state_e  state_q, state_d;
    bundle_t dec, out_q, skid_q;
    logic    ready_q;
    logic    in_xfer, out_xfer;
    logic    load_out, load_skid, skid_to_out;

    assign in_xfer  = i_instr_valid & ready_q;
    assign out_xfer = (state_q != EMPTY) & i_decode_ready;

    always_comb begin
        // NOTE: default every field first so no path through this block can infer a latch.
        dec           = '0;
        dec.pc        = i_pc;
        dec.funct3    = i_instr[14:12];
        dec.funct7    = i_instr[31:25];
        dec.rs1       = i_instr[19:15];
        dec.rs2       = i_instr[24:20];
        dec.rd        = i_instr[11:7];
        dec.rd_wen    = is_rd_opcode(i_instr) && (i_instr[11:7] != 5'd0);
        dec.imm       = DATA_WIDTH'(signed'(get_imm(i_instr)));
        dec.is_imm    = is_imm_op(i_instr);
        dec.is_jump   = is_jump_op(i_instr);
        dec.is_branch = is_branch_op(i_instr);
        dec.is_load   = is_load_op(i_instr);
        dec.is_store  = is_store_op(i_instr);
`ifdef BC_ID_ILLEGAL_CHECK_EN
        dec.illegal   = (i_instr[1:0] != 2'b11) || !is_legal_opcode(i_instr);
        if (dec.illegal) begin
            dec.rd_wen    = 1'b0;
            dec.is_imm    = 1'b0;
            dec.is_jump   = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
        end
`endif
    end

    // Ready is registered from the next state, so there is no comb path ready-in -> ready-out.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (in_xfer) state_d = ONE;
            ONE: begin
                if (in_xfer && !out_xfer)      state_d = TWO;
                else if (!in_xfer && out_xfer) state_d = EMPTY;
            end
            TWO:     if (out_xfer) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (i_flush) state_d = EMPTY;
    end

    always_comb begin
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        if (!i_flush) begin
            case (state_q)
                EMPTY:   load_out    = in_xfer;
                ONE: begin
                    load_out  = in_xfer & out_xfer;
                    load_skid = in_xfer & ~out_xfer;
                end
                TWO:     skid_to_out = out_xfer;
                default: ;
            endcase
        end
    end

    // NOTE: the two bundle registers are reset because the bundle outputs must read 0 after reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (skid_to_out)   out_q <= skid_q;
            else if (load_out) out_q <= dec;
            if (load_skid)     skid_q <= dec;
        end
    end

    assign o_instr_ready  = ready_q;
    assign o_decode_valid = (state_q != EMPTY);
    assign o_pc           = out_q.pc;
    assign o_funct3       = out_q.funct3;
    assign o_funct7       = out_q.funct7;
    assign o_rs1_addr     = out_q.rs1;
    assign o_rs2_addr     = out_q.rs2;
    assign o_rd_addr      = out_q.rd;
    assign o_rd_wen       = out_q.rd_wen;
    assign o_imm          = out_q.imm;
    assign o_is_imm_op    = out_q.is_imm;
    assign o_is_jump_op   = out_q.is_jump;
    assign o_is_branch_op = out_q.is_branch;
    assign o_is_load_op   = out_q.is_load;
    assign o_is_store_op  = out_q.is_store;
`ifdef BC_ID_ILLEGAL_CHECK_EN
    assign o_illegal      = out_q.illegal;
`else
    assign o_illegal      = 1'b0;
`endif

endmodule

// File: tb/tb_bc_stage_id_hs.sv
// Scoreboard bench for bc_stage_id_hs: decoded bundles are queued on input accept
// and compared in order on output accept.

module tb_bc_stage_id_hs;

`ifdef BC_ID_ILLEGAL_CHECK_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_instr_valid = 1'b0;
    logic        o_instr_ready;
    logic [31:0] i_instr = '0;
    logic [31:0] i_pc = '0;
    logic        o_decode_valid;
    logic        i_decode_ready = 1'b0;
    logic [31:0] o_pc;
    logic [2:0]  o_funct3;
    logic [6:0]  o_funct7;
    logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
    logic        o_rd_wen;
    logic [31:0] o_imm;
    logic        o_is_imm_op, o_is_jump_op, o_is_branch_op, o_is_load_op, o_is_store_op;
    logic        o_illegal;

    bc_stage_id_hs dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_flush(i_flush),
        .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready),
        .i_instr(i_instr), .i_pc(i_pc),
        .o_decode_valid(o_decode_valid), .i_decode_ready(i_decode_ready),
        .o_pc(o_pc), .o_funct3(o_funct3), .o_funct7(o_funct7),
        .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr),
        .o_rd_wen(o_rd_wen), .o_imm(o_imm),
        .o_is_imm_op(o_is_imm_op), .o_is_jump_op(o_is_jump_op),
        .o_is_branch_op(o_is_branch_op), .o_is_load_op(o_is_load_op),
        .o_is_store_op(o_is_store_op), .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    // Hand-decoded reference table: instruction, immediate, rd write enable,
    // class mask {imm, jump, branch, load, store}, illegal flag.
    localparam int N = 11;
    logic [31:0] tab_instr [N] = '{32'h00510093, 32'h00000013, 32'hFFC52283, 32'h00612423,
                                   32'hFE208CE3, 32'h010000EF, 32'h123451B7, 32'h009403B3,
                                   32'h00008067, 32'hFFFF8F93, 32'hFFFFFFFF};
    logic [31:0] tab_imm [N]   = '{32'd5, 32'd0, 32'hFFFFFFFC, 32'd8, 32'hFFFFFFF8, 32'd16,
                                   32'h12345000, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0};
    logic        tab_wen [N]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [4:0]  tab_cls [N]   = '{5'b10000, 5'b10000, 5'b00010, 5'b00001, 5'b00100, 5'b01000,
                                   5'b00000, 5'b00000, 5'b01000, 5'b10000, 5'b00000};

    int n_checks = 0;
    int n_fail   = 0;
    logic [95:0] sb [$];
    logic        stall_prev = 1'b0;
    logic [95:0] stall_vec = '0;
    logic [31:0] pc_ctr = 32'h1000;
    logic        acc;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] out_vec();
        return {o_pc, o_funct3, o_funct7, o_rs1_addr, o_rs2_addr, o_rd_addr, o_rd_wen, o_imm,
                o_is_imm_op, o_is_jump_op, o_is_branch_op, o_is_load_op, o_is_store_op, o_illegal};
    endfunction

    function automatic logic [95:0] exp_vec(input int idx, input logic [31:0] pc);
        logic [31:0] ins;
        ins = tab_instr[idx];
        return {pc, ins[14:12], ins[31:25], ins[19:15], ins[24:20], ins[11:7], tab_wen[idx],
                tab_imm[idx], tab_cls[idx], (idx == N - 1) ? ILL : 1'b0};
    endfunction

    // One cycle: drive at negedge, sample 1 ns later, predict the coming posedge.
    task automatic cycle(input logic v, input int idx, input logic dr, input logic fl,
                         output logic accepted);
        @(negedge i_clk);
        i_instr_valid  = v;
        i_instr        = tab_instr[idx];
        i_pc           = pc_ctr;
        i_decode_ready = dr;
        i_flush        = fl;
        #1;
        if (stall_prev) check("stall_hold", out_vec(), stall_vec);
        accepted = v & o_instr_ready;
        if (o_decode_valid && dr) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) check("bundle", out_vec(), sb.pop_front());
        end
        stall_prev = o_decode_valid & ~dr & ~fl;
        stall_vec  = out_vec();
        if (fl) sb.delete();
        else if (accepted) sb.push_back(exp_vec(idx, pc_ctr));
        pc_ctr += 32'd4;
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 20 && sb.size() != 0; i++) cycle(1'b0, 0, 1'b1, 1'b0, a);
        check("drain_empty", sb.size(), 0);
        cycle(1'b0, 0, 1'b1, 1'b0, a);
        check("drain_valid_low", o_decode_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, timeout reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge i_clk);
        #1;
        check("rst_valid", o_decode_valid, 0);
        check("rst_ready", o_instr_ready, 1);
        check("rst_bundle", out_vec(), 0);
        @(negedge i_clk);
        i_rstn = 1'b1;

        // addi x1,x2,5 then nop
        cycle(1'b1, 0, 1'b1, 1'b0, acc);
        check("t1_accept", acc, 1);
        cycle(1'b0, 0, 1'b1, 1'b0, acc);
        check("t1_valid", o_decode_valid, 1);
        check("t1_fields", {o_rs1_addr, o_rd_addr, o_imm, o_is_imm_op, o_rd_wen},
              {5'd2, 5'd1, 32'd5, 1'b1, 1'b1});
        cycle(1'b1, 1, 1'b1, 1'b0, acc);
        cycle(1'b0, 0, 1'b1, 1'b0, acc);
        check("t2_fields", {o_rd_wen, o_is_imm_op, o_imm}, {1'b0, 1'b1, 32'd0});
        drain();

        // back-pressure fills the skid register
        cycle(1'b1, 2, 1'b0, 1'b0, acc);
        cycle(1'b1, 3, 1'b0, 1'b0, acc);
        cycle(1'b1, 4, 1'b0, 1'b0, acc);
        check("t3_ready_low", o_instr_ready, 0);
        check("t3_valid", o_decode_valid, 1);
        check("t3_third_refused", acc, 0);
        cycle(1'b0, 0, 1'b0, 1'b0, acc);
        drain();

        // flush in state TWO, then flush while an input is accepted in state ONE
        cycle(1'b1, 4, 1'b0, 1'b0, acc);
        cycle(1'b1, 5, 1'b0, 1'b0, acc);
        cycle(1'b1, 6, 1'b0, 1'b1, acc);
        cycle(1'b0, 0, 1'b0, 1'b0, acc);
        check("t4_flush_valid", o_decode_valid, 0);
        check("t4_flush_ready", o_instr_ready, 1);
        cycle(1'b1, 7, 1'b0, 1'b0, acc);
        cycle(1'b1, 8, 1'b0, 1'b1, acc);
        check("t4_flush_in_accepted", acc, 1);
        cycle(1'b0, 0, 1'b1, 1'b0, acc);
        check("t4_drop_valid", o_decode_valid, 0);
        drain();

        // streaming with decode_ready toggling every cycle
        begin
            int k = 0;
            for (int c = 0; c < 100 && k < 8; c++) begin
                cycle(1'b1, k, c[0], 1'b0, acc);
                if (acc) k++;
            end
            check("t5_all_sent", k, 8);
        end
        drain();

        // illegal instruction
        cycle(1'b1, N - 1, 1'b0, 1'b0, acc);
        cycle(1'b0, 0, 1'b0, 1'b0, acc);
        check("t6_illegal", {o_illegal, o_rd_wen, o_is_imm_op, o_is_jump_op, o_is_branch_op,
                             o_is_load_op, o_is_store_op}, {ILL, 6'b0});
        drain();

        // random traffic
        for (int c = 0; c < 300; c++)
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0), acc);
        drain();

        // asynchronous reset mid-operation
        cycle(1'b1, 5, 1'b0, 1'b0, acc);
        cycle(1'b1, 9, 1'b0, 1'b0, acc);
        @(negedge i_clk);
        i_instr_valid = 1'b0;
        #2 i_rstn = 1'b0;
        #1;
        check("mid_rst_valid", o_decode_valid, 0);
        check("mid_rst_ready", o_instr_ready, 1);
        check("mid_rst_bundle", out_vec(), 0);
        sb.delete();
        stall_prev = 1'b0;
        @(negedge i_clk);
        i_rstn = 1'b1;
        cycle(1'b1, 3, 1'b1, 1'b0, acc);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
